// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous memory among
// NREQ requesters: latch a winner, issue one transaction, wait for the
// memory's registered ready (or time out), then pulse completion/error.
module mem_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_wr_rd,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]      req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic [NREQ-1:0]            req_err,
  output logic                       m_valid,
  output logic                       m_wr_rd,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic [WIDTH-1:0]           m_wdata,
  input  logic                       m_ready,
  input  logic [WIDTH-1:0]           m_rdata,
  output logic                       busy
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [GW-1:0]         grant, grant_n;
  logic [GW-1:0]         last_grant, last_grant_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  m_valid_n, m_wr_rd_n, busy_n;
  logic [ADDR_WIDTH-1:0] m_addr_n;
  logic [WIDTH-1:0]      m_wdata_n, rsp_rdata_n;
  logic [NREQ-1:0]       req_ready_n, req_err_n;
  logic [GW-1:0]         pick, try_idx;
  logic                  found;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_wr_rd    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_rdata  <= '0;
      req_ready  <= '0;
      req_err    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      m_valid    <= m_valid_n;
      m_wr_rd    <= m_wr_rd_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      rsp_rdata  <= rsp_rdata_n;
      req_ready  <= req_ready_n;
      req_err    <= req_err_n;
      busy       <= busy_n;
    end
  end

  // Round-robin search starting just after the last winner, with wrap
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    try_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      try_idx = GW'((32'(last_grant) + k) % NREQ);
      if (!found && req_valid[try_idx]) begin
        found = 1'b1;
        pick  = try_idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    m_valid_n    = 1'b0;
    m_wr_rd_n    = m_wr_rd;
    m_addr_n     = m_addr;
    m_wdata_n    = m_wdata;
    rsp_rdata_n  = rsp_rdata;
    req_ready_n  = '0;
    req_err_n    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = ISSUE;
          grant_n      = pick;
          last_grant_n = pick;
          m_valid_n    = 1'b1;
          m_wr_rd_n    = req_wr_rd[pick];
          m_addr_n     = req_addr[32'(pick) * ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_n    = req_wdata[32'(pick) * WIDTH +: WIDTH];
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        if (m_ready) begin
          state_n            = DONE;
          req_ready_n[grant] = 1'b1;
          if (!m_wr_rd) rsp_rdata_n = m_rdata;
        end else begin
          cnt_n = cnt + CW'(1);
          if (32'(cnt_n) == TIMEOUT) begin
            state_n          = IDLE;
            req_err_n[grant] = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small single-port memory model.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_wr_rd = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready, req_err;
  logic [DW-1:0]      rsp_rdata;
  logic               m_valid, m_wr_rd, busy;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_ready;
  logic [DW-1:0]      m_rdata;

  logic               stall = 1'b0;
  logic [DW-1:0]      mem [256];
  logic [255:0]       written;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .WIDTH(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_rdata(rsp_rdata),
    .req_err(req_err), .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back as C0DE00xx
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Memory: ready and read data registered one cycle after valid
  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      written <= '0;
    end else begin
      m_ready <= m_valid && !stall;
      if (m_valid && !stall) begin
        if (m_wr_rd) begin
          mem[m_addr]     <= m_wdata;
          written[m_addr] <= 1'b1;
        end else begin
          m_rdata <= written[m_addr] ? mem[m_addr] : init_val(m_addr);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr_rd[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction, checked cycle by cycle
  task automatic run_single(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    tick();
    set_req(i, wr, a, d);
    tick();
    check("issue_valid", 64'(m_valid), 64'd1);
    check("issue_addr", 64'(m_addr), 64'(a));
    check("issue_wr", 64'(m_wr_rd), 64'(wr));
    if (wr) check("issue_wdata", 64'(m_wdata), 64'(d));
    check("issue_busy", 64'(busy), 64'd1);
    tick();
    check("wait_valid", 64'(m_valid), 64'd0);
    check("wait_addr_hold", 64'(m_addr), 64'(a));
    tick();
    check("done_ready", 64'(req_ready), 64'(4'b0001 << i));
    check("done_err", 64'(req_err), 64'd0);
    check("done_rdata", 64'(rsp_rdata), 64'(exp_rd));
    req_valid[i] = 1'b0;
    tick();
    check("after_ready", 64'(req_ready), 64'd0);
    check("after_busy", 64'(busy), 64'd0);
  endtask

  // Wait (bounded) for the next ready/err pulse; optionally drop the winner
  task automatic wait_done(input logic [NREQ-1:0] clr, output int idx, output logic is_err,
                           output logic [DW-1:0] rd);
    logic found = 1'b0;
    idx = -1;
    is_err = 1'b0;
    rd = '0;
    for (int n = 0; n < 60 && !found; n++) begin
      tick();
      if ((req_ready | req_err) != '0) begin
        found = 1'b1;
        check("pulse_onehot", 64'($countones(req_ready | req_err)), 64'd1);
        for (int i = 0; i < int'(NREQ); i++)
          if (req_ready[i] || req_err[i]) idx = i;
        is_err = |req_err;
        rd = rsp_rdata;
        if (clr[idx]) req_valid[idx] = 1'b0;
      end
    end
    check("wait_bound", 64'(found), 64'd1);
  endtask

  initial begin
    int idx, t0, tprev;
    logic e;
    logic [DW-1:0] rd;
    int exp_fair [6] = '{0, 2, 0, 2, 0, 1};

    // Reset values
    do_reset();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_err", 64'(req_err), 64'd0);
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_maddr", 64'(m_addr), 64'd0);

    // Single write then read by requester 0
    run_single(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0);
    run_single(0, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF);

    // All four read at once after reset: order 0,1,2,3, four cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h20 + i), 32'h0);
    tprev = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_done(4'b1111, idx, e, rd);
      check("all4_idx", 64'(idx), 64'(i));
      check("all4_err", 64'(e), 64'd0);
      check("all4_rdata", 64'(rd), 64'(32'hC0DE_0020 + i));
      check("all4_busy", 64'(busy), 64'd1);
      check("all4_gap", 64'(cyc - tprev), (i == 0) ? 64'd3 : 64'd4);
      tprev = cyc;
    end

    // Fairness: req0/req2 held, req1 joins mid-stream
    tick();
    set_req(0, 1'b0, 8'h40, 32'h0);
    set_req(2, 1'b0, 8'h42, 32'h0);
    for (int k = 0; k < 6; k++) begin
      wait_done(4'b0010, idx, e, rd);
      check("fair_idx", 64'(idx), 64'(exp_fair[k]));
      check("fair_rdata", 64'(rd), 64'(32'hC0DE_0040 + exp_fair[k]));
      if (k == 3) set_req(1, 1'b0, 8'h41, 32'h0);
    end
    req_valid = '0;
    tick();
    tick();
    check("fair_idle", 64'(busy), 64'd0);

    // Timeout: memory never answers
    stall = 1'b1;
    set_req(1, 1'b0, 8'h30, 32'h0);
    t0 = cyc;
    wait_done(4'b0010, idx, e, rd);
    check("to_is_err", 64'(e), 64'd1);
    check("to_err_vec", 64'(req_err), 64'b0010);
    check("to_no_ready", 64'(req_ready), 64'd0);
    check("to_latency", 64'(cyc - t0), 64'd17);
    check("to_idle", 64'(busy), 64'd0);
    stall = 1'b0;
    run_single(1, 1'b0, 8'h31, 32'h0, 32'hC0DE_0031);

    // Reset while in WAIT
    set_req(2, 1'b0, 8'h52, 32'h0);
    tick();
    tick();
    check("pre_rst_wait", 64'(m_valid), 64'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_all", 64'({req_ready, req_err, m_valid, m_wr_rd, busy}), 64'd0);
    check("mid_rst_data", 64'({m_addr, m_wdata}), 64'd0);
    check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
    req_valid = '0;
    tick();
    check("mid_rst_ready2", 64'(req_ready), 64'd0);
    rst = 1'b0;
    set_req(3, 1'b0, 8'h53, 32'h0);
    set_req(0, 1'b0, 8'h50, 32'h0);
    wait_done(4'b1111, idx, e, rd);
    check("post_rst_first", 64'(idx), 64'd0);
    check("post_rst_rd0", 64'(rd), 64'(32'hC0DE_0050));
    wait_done(4'b1111, idx, e, rd);
    check("post_rst_second", 64'(idx), 64'd3);
    check("post_rst_rd3", 64'(rd), 64'(32'hC0DE_0053));

    // Write completion leaves rsp_rdata at the previous read value
    run_single(3, 1'b1, 8'hFF, 32'h0000_0055, 32'hC0DE_0053);
    run_single(3, 1'b0, 8'hFF, 32'h0, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
